// File: rtl/tz_sec_tagger.sv
`default_nettype none
// tz_sec_tagger: classifies read beats against a region table, blocks non-secure access to
// secure regions and buffers tagged beats in a FIFO. Macro TZ_TAGGER_VIOL_CNT_EN adds viol_cnt.
module tz_sec_tagger #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic              in_ns,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic              cfg_en,
  input  logic              cfg_secure,
  input  logic              cfg_lock,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_security_level,
  output logic              out_fault
`ifdef TZ_TAGGER_VIOL_CNT_EN
  ,
  output logic [7:0]        viol_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [DEPTH:0] FULL = (DEPTH+1)'(DEPTH);

  logic [ADDR_W-1:0] base_q  [NREG];
  logic [ADDR_W-1:0] limit_q [NREG];
  logic [NREG-1:0]   en_q, sec_q;
  logic              lock_q;

  logic [31:0]       data_mem_q [DEPTH];
  logic [DEPTH-1:0]  lvl_mem_q, flt_mem_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DEPTH:0]    count_q, count_d;

  logic              push, pop, hit_sec, viol, lvl_new;
  logic [31:0]       data_new;

  // Scan from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    hit_sec = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (en_q[i] && (in_addr >= base_q[i]) && (in_addr <= limit_q[i])) begin
        hit_sec = sec_q[i];
      end
    end
  end

  assign viol     = hit_sec & in_ns;
  assign lvl_new  = ~hit_sec;
  assign data_new = viol ? 32'h0 : in_data;

  assign in_ready  = !rst_n && (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data           = data_mem_q[rd_ptr_q];
  assign out_security_level = lvl_mem_q[rd_ptr_q];
  assign out_fault          = flt_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (DEPTH+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (DEPTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lvl_mem_q <= '0;
      flt_mem_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= 32'h0;
      end
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= data_new;
        lvl_mem_q[wr_ptr_q]  <= lvl_new;
        flt_mem_q[wr_ptr_q]  <= viol;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // A write in the lock cycle still lands; the lock only gates later writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      en_q   <= '0;
      sec_q  <= '0;
      lock_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
      end
    end else begin
      if (cfg_we && !lock_q) begin
        for (int i = 0; i < NREG; i++) begin
          if (cfg_idx == 3'(i)) begin
            base_q[i]  <= cfg_base;
            limit_q[i] <= cfg_limit;
            en_q[i]    <= cfg_en;
            sec_q[i]   <= cfg_secure;
          end
        end
      end
      if (cfg_lock) begin
        lock_q <= 1'b1;
      end
    end
  end

`ifdef TZ_TAGGER_VIOL_CNT_EN
  logic [7:0] viol_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      viol_cnt_q <= 8'h0;
    end else if (push && viol && (viol_cnt_q != 8'hFF)) begin
      viol_cnt_q <= viol_cnt_q + 8'h1;
    end
  end

  assign viol_cnt = viol_cnt_q;
`else
  // Violation counter not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_tz_sec_tagger.sv
`default_nettype none
// Scoreboard bench for tz_sec_tagger: reference model at accept, monitor compares at the head.
module tb_tz_sec_tagger;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int NREG   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0, in_ready, in_ns = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [31:0]       in_data = '0;
  logic              cfg_we = 1'b0, cfg_en = 1'b0, cfg_secure = 1'b0, cfg_lock = 1'b0;
  logic [2:0]        cfg_idx = '0;
  logic [ADDR_W-1:0] cfg_base = '0, cfg_limit = '0;
  logic              out_valid, out_ready = 1'b1, out_security_level, out_fault;
  logic [31:0]       out_data;
`ifdef TZ_TAGGER_VIOL_CNT_EN
  logic [7:0]        viol_cnt;
`endif

  tz_sec_tagger #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data), .in_ns(in_ns),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cfg_en(cfg_en), .cfg_secure(cfg_secure), .cfg_lock(cfg_lock),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_security_level(out_security_level), .out_fault(out_fault)
`ifdef TZ_TAGGER_VIOL_CNT_EN
    , .viol_cnt(viol_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic        lvl;
    logic        flt;
  } beat_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t q[$];

  logic [31:0] m_base [8];
  logic [31:0] m_limit[8];
  bit          m_en [8];
  bit          m_sec[8];
  bit          m_lock;
  int          m_viol;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected tag from the region rules: first enabled region containing the address decides.
  function automatic beat_t tag_of(input logic [31:0] a, input logic [31:0] d, input logic ns);
    for (int i = 0; i < NREG; i++) begin
      if (m_en[i] && a >= m_base[i] && a <= m_limit[i]) begin
        if (!m_sec[i]) return {d, 1'b1, 1'b0};
        if (ns)        return {32'h0, 1'b0, 1'b1};
        return {d, 1'b0, 1'b0};
      end
    end
    return {d, 1'b1, 1'b0};
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 0; m_sec[i] = 0; m_base[i] = '0; m_limit[i] = '0;
    end
    m_lock = 0;
    m_viol = 0;
  endtask

  // Reference model: sees each edge's inputs shortly after the preceding falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      model_clear();
    end else begin
      if (in_valid && in_ready) begin
        beat_t b;
        b = tag_of(in_addr, in_data, in_ns);
        q.push_back(b);
        if (b.flt && m_viol < 255) m_viol++;
      end
      if (cfg_we && !m_lock && int'(cfg_idx) < NREG) begin
        m_base[cfg_idx]  = cfg_base;
        m_limit[cfg_idx] = cfg_limit;
        m_en[cfg_idx]    = cfg_en;
        m_sec[cfg_idx]   = cfg_secure;
      end
      if (cfg_lock) m_lock = 1;
    end
  end

  // Monitor: compares handshake and head against the scoreboard, pops on transfer.
  always @(negedge clk) begin
    check("in_ready", in_ready, (!rst_n && q.size() != DEPTH));
    check("out_valid", out_valid, (q.size() != 0));
    if (out_valid && q.size() != 0) begin
      check("out_data", out_data, q[0].d);
      check("out_level", out_security_level, q[0].lvl);
      check("out_fault", out_fault, q[0].flt);
      if (out_ready && !rst_n) void'(q.pop_front());
    end
`ifdef TZ_TAGGER_VIOL_CNT_EN
    if (!rst_n) check("viol_cnt", viol_cnt, m_viol[7:0]);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic ns);
    in_valid = 1'b1; in_addr = a; in_data = d; in_ns = ns;
    step();
    in_valid = 1'b0;
  endtask

  task automatic cfgw(input int idx, input logic [31:0] b, input logic [31:0] l,
                      input logic en, input logic sec);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_base = b; cfg_limit = l; cfg_en = en; cfg_secure = sec;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_level", out_security_level, 1'b0);
    check("rst_out_fault", out_fault, 1'b0);

    cfgw(0, 32'h1000, 32'h1FFF, 1'b1, 1'b1);
    beat(32'h1800, 32'hDEADBEEF, 1'b0);
    check("lat_valid", out_valid, 1'b1);
    check("lat_data", out_data, 32'hDEADBEEF);
    beat(32'h1800, 32'hCAFEF00D, 1'b1);
    check("viol_data", out_data, 32'h0);
    check("viol_fault", out_fault, 1'b1);
    beat(32'h5000, 32'h12345678, 1'b0);
    check("nomatch_level", out_security_level, 1'b1);
    beat(32'h1000, 32'h0BADF00D, 1'b1);
    beat(32'h1FFF, 32'h00C0FFEE, 1'b1);
    beat(32'h2000, 32'h22220000, 1'b1);
    step();

    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) beat(32'h1800 + 32'(i), 32'hA0000000 + 32'(i), 1'(i & 1));
    check("full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_addr = 32'h5000; in_data = 32'hBBBB0001; in_ns = 1'b0;
    repeat (2) step();
    in_valid = 1'b0;
    repeat (DEPTH + 2) step();

    cfg_lock = 1'b1;
    step();
    cfg_lock = 1'b0;
    cfgw(0, 32'h1000, 32'h1FFF, 1'b1, 1'b0);
    beat(32'h1800, 32'h11112222, 1'b0);
    check("locked_level", out_security_level, 1'b0);
    step();

    out_ready = 1'b0;
    beat(32'h5000, 32'h33334444, 1'b0);
    beat(32'h5004, 32'h55556666, 1'b0);
    rst_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    cfgw(0, 32'h1000, 32'h1FFF, 1'b1, 1'b0);
    beat(32'h1800, 32'h77778888, 1'b1);
    check("unlock_level", out_security_level, 1'b1);
    step();

    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(9) < 7);
      in_addr   = 32'($urandom_range(32'h3FF));
      in_data   = $urandom;
      in_ns     = 1'($urandom);
      out_ready = ($urandom_range(9) < 7);
      cfg_we    = ($urandom_range(19) == 0);
      cfg_idx   = 3'($urandom_range(7));
      cfg_base  = 32'($urandom_range(32'h3FF));
      cfg_limit = cfg_base + 32'($urandom_range(32'h180));
      cfg_en    = 1'($urandom);
      cfg_secure = 1'($urandom);
      cfg_lock  = ($urandom_range(299) == 0);
      rst_n     = ($urandom_range(399) == 0);
      step();
    end
    in_valid = 1'b0; cfg_we = 1'b0; cfg_lock = 1'b0; rst_n = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 3) step();
    check("drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tz_sec_tagger.md
# tz_sec_tagger

Ingress stage directly upstream of `tz_peripheral`. It accepts read-data beats from the bus fabric, classifies each beat against a programmable table of address regions, and blocks non-secure access to secure regions. It buffers tagged beats in a small FIFO and presents each one as data plus a one-bit security level. That level is the value driven into the peripheral's `data_in_security_level` (0 = secure, 1 = non-secure).

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: beat address width.
- `NREG`, 4: number of region-table entries, 1..8.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-high reset (1 = reset asserted), sampled on `clk`.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_addr`  in  ADDR_W  beat address.
- `in_data`  in  32  beat data.
- `in_ns`  in  1  requester attribute: 1 = non-secure requester.
- `cfg_we`  in  1  region-table write strobe.
- `cfg_idx`  in  3  entry index; writes with idx ≥ NREG are ignored.
- `cfg_base`, `cfg_limit`  in  ADDR_W  inclusive region bounds.
- `cfg_en`  in  1  entry enable.
- `cfg_secure`  in  1  region is secure.
- `cfg_lock`  in  1  pulse: sets the sticky table lock.
- `out_valid`  out  1  tagged beat available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  32  beat data (zeroed on violation).
- `out_security_level`  out  1  0 = secure, 1 = non-secure.
- `out_fault`  out  1  beat was a security violation.
- `viol_cnt`  out  8  saturating violation count; present only with the config macro.

## Operation
- Accept: a beat is accepted when `in_valid && in_ready`; `in_ready = (count != DEPTH)`.
- Lookup (combinational at accept):
  - An entry matches when `en && base <= in_addr <= limit` (unsigned compare).
  - The lowest matching index wins.
  - If no entry matches, the beat is treated as a non-secure region.
- Tagging:
  - Non-secure region: `security_level = 1`, data passed, `fault = 0`.
  - Secure region with `in_ns = 0`: `security_level = 0`, data passed, `fault = 0`.
  - Secure region with `in_ns = 1` (violation): `data = 0`, `security_level = 0`, `fault = 1`.
- FIFO:
  - Each stored entry is {data, level, fault}.
  - Head presented on `out_*`; popped when `out_valid && out_ready`.
  - `out_valid = (count != 0)`.
- Full with simultaneous pop: `in_ready` is still 0 (no bypass), so no push that cycle.
- Empty: push and pop cannot coincide, because `out_valid` is 0.
- Counter: `count` is DEPTH+1 wide; read and write pointers wrap modulo DEPTH.
- Config:
  - A write updates the entry at the clock edge.
  - Beats accepted in the same cycle use the old table contents.
  - The lock is set by `cfg_lock` and, once set, blocks all `cfg_we` writes until reset.
  - Lock and write in the same cycle: the write takes effect and the lock is set.
- Registered outputs: `out_data`, `out_security_level` and `out_fault` come from FIFO storage and do not depend combinationally on `in_*`.

## Timing
- Reset values (cycle after `rst_n` = 1):
  - Outputs: `out_valid = 0`, `in_ready = 0` while reset is held, `out_data = 0`, `out_security_level = 0`, `out_fault = 0`, `viol_cnt = 0`.
  - Internal state: all table entries disabled, lock clear, pointers and count 0.
- `in_ready` returns to 1 the first cycle after reset deasserts.
- Latency: a beat accepted at edge N into an empty FIFO gives `out_valid = 1` after edge N, i.e. visible in cycle N+1.
- Throughput: one beat per cycle sustained when `out_ready` is held at 1.
- Reset mid-operation: all buffered beats are discarded with no partial output; the table is cleared.
- Head stability: `out_*` hold stable while `out_valid && !out_ready`.

## Configuration
- `TZ_TAGGER_VIOL_CNT_EN` defined:
  - `viol_cnt` port present.
  - Increments by 1 on each accepted violation beat (at accept, not at pop).
  - Saturates at 255 and clears only on reset.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then idle → `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_security_level = 0`.
- Entry 0 = {0x1000..0x1FFF, secure, en}; beat addr 0x1800, data 0xDEADBEEF, `in_ns = 0` → next cycle `out_data = 0xDEADBEEF`, level 0, fault 0.
- Same table; beat addr 0x1800, `in_ns = 1` → `out_data = 0`, level 0, fault 1, `viol_cnt = 1` (with macro).
- Beat at addr 0x5000 (no match), data 0x12345678 → level 1, data passed.
- Hold `out_ready = 0`, push DEPTH = 4 beats → `in_ready = 0`. Then assert `out_ready` with `in_valid = 1` → first pop does not accept a push; order preserved.
- Set lock, then write entry 0 as non-secure → table unchanged, addr 0x1800 still tagged secure. Assert reset mid-stream → `out_valid = 0`, lock clear.
